// File: rtl/oai_result_checker.sv
// oai_result_checker
//   Watches the shared OAI stimulus (a, b, c) and N_DUT variant outputs. It
//   waits until the sampled stimulus has been stable for SETTLE cycles, then
//   compares every variant against y = ~((a | b) & c) exactly once per
//   settled vector. It keeps saturating error and check counters, a sticky
//   per-variant fail mask, and the first failing vector.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   a, b, c       stimulus shared with the variants
//   dut_y         variant outputs, bit i = variant i
//   clear         synchronous statistics clear, also restarts settling
//   err_cnt       (vector, variant) mismatches, saturating
//   check_cnt     settled vectors compared, saturating
//   err_mask      sticky per-variant mismatch flags
//   first_vec     {a,b,c} of the first mismatching vector
//   first_valid   first_vec holds a captured vector
//   busy          waiting for the stimulus to settle
//   pass          at least one compare and no mismatch seen

// Single-lane compare. Case inequality makes an X/Z output a mismatch.
module oai_lane_cmp (
    input  logic y,
    input  logic golden,
    output logic mis
);
    assign mis = (y !== golden);
endmodule

module oai_result_checker #(
    parameter int N_DUT  = 3,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic [N_DUT-1:0] dut_y,
    input  logic             clear,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] check_cnt,
    output logic [N_DUT-1:0] err_mask,
    output logic [2:0]       first_vec,
    output logic             first_valid,
    output logic             busy,
    output logic             pass
);
    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam int PC_W  = $clog2(N_DUT + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [2:0]       abc_q, abc_prev;
    logic [1:0]       state;
    logic [7:0]       settle_cnt;
    logic             change, golden, do_cmp;
    logic [N_DUT-1:0] mis;
    logic [PC_W-1:0]  mis_cnt;
    logic [SUM_W-1:0] err_sum;
    logic [CNT_W-1:0] err_nxt, chk_nxt;

    assign change = (abc_q != abc_prev);
    assign golden = ~((abc_q[2] | abc_q[1]) & abc_q[0]);

    for (genvar i = 0; i < N_DUT; i++) begin : g_lane
        oai_lane_cmp u_cmp (
            .y      (dut_y[i]),
            .golden (golden),
            .mis    (mis[i])
        );
    end

    always_comb begin
        mis_cnt = '0;
        for (int i = 0; i < N_DUT; i++) mis_cnt = mis_cnt + PC_W'(mis[i]);
    end

    // Add in a wider width so the saturation test cannot wrap.
    assign err_sum = SUM_W'(err_cnt) + SUM_W'(mis_cnt);
    assign err_nxt = (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
    assign chk_nxt = (check_cnt == CNT_MAX) ? check_cnt : check_cnt + CNT_W'(1);

    // A change during the CHECK cycle means the vector was not really
    // settled, so the compare is dropped; clear also discards it.
    assign do_cmp = (state == ST_CHECK) && !change && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abc_q       <= '0;
            abc_prev    <= '0;
            state       <= ST_SETTLE;
            settle_cnt  <= SETTLE_LD;
            err_cnt     <= '0;
            check_cnt   <= '0;
            err_mask    <= '0;
            first_vec   <= '0;
            first_valid <= 1'b0;
        end else begin
            abc_q    <= {a, b, c};
            abc_prev <= abc_q;

            if (clear) begin
                state       <= ST_SETTLE;
                settle_cnt  <= SETTLE_LD;
                err_cnt     <= '0;
                check_cnt   <= '0;
                err_mask    <= '0;
                first_vec   <= '0;
                first_valid <= 1'b0;
            end else begin
                case (state)
                    ST_SETTLE: begin
                        if (change)
                            settle_cnt <= SETTLE_LD;
                        else if (settle_cnt <= 8'd1)
                            state <= ST_CHECK;
                        else
                            settle_cnt <= settle_cnt - 8'd1;
                    end
                    ST_CHECK: begin
                        if (change) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (change) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end
                    end
                    default: begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LD;
                    end
                endcase

                if (do_cmp) begin
                    err_cnt   <= err_nxt;
                    check_cnt <= chk_nxt;
                    err_mask  <= err_mask | mis;
                    if ((|mis) && !first_valid) begin
                        first_vec   <= abc_q;
                        first_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy = (state == ST_SETTLE);
    assign pass = (check_cnt != '0) && !first_valid;

endmodule

// File: tb/tb_oai_result_checker.sv
module tb_oai_result_checker;
    localparam int N_DUT = 3, SETTLE = 4, CNT_W = 8, CNT_WS = 3;

    logic clk = 1'b0;
    logic rst_n, a, b, c, clear;
    logic [N_DUT-1:0] dut_y;

    logic [CNT_W-1:0]  err_cnt, check_cnt;
    logic [N_DUT-1:0]  err_mask;
    logic [2:0]        first_vec;
    logic              first_valid, busy, pass;

    logic [CNT_WS-1:0] s_err_cnt, s_check_cnt;
    logic [N_DUT-1:0]  s_err_mask;
    logic [2:0]        s_first_vec;
    logic              s_first_valid, s_busy, s_pass;

    logic [CNT_W-1:0]  u_err_cnt, u_check_cnt;
    logic [N_DUT-1:0]  u_err_mask;
    logic [2:0]        u_first_vec;
    logic              u_first_valid, u_busy, u_pass;

    always #5 clk = ~clk;

    oai_result_checker #(.N_DUT(N_DUT), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .dut_y(dut_y), .clear(clear),
        .err_cnt(err_cnt), .check_cnt(check_cnt), .err_mask(err_mask),
        .first_vec(first_vec), .first_valid(first_valid), .busy(busy), .pass(pass));

    oai_result_checker #(.N_DUT(N_DUT), .SETTLE(SETTLE), .CNT_W(CNT_WS)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .dut_y(dut_y), .clear(clear),
        .err_cnt(s_err_cnt), .check_cnt(s_check_cnt), .err_mask(s_err_mask),
        .first_vec(s_first_vec), .first_valid(s_first_valid), .busy(s_busy), .pass(s_pass));

    oai_result_checker #(.N_DUT(N_DUT), .SETTLE(1), .CNT_W(CNT_W)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .dut_y(dut_y), .clear(clear),
        .err_cnt(u_err_cnt), .check_cnt(u_check_cnt), .err_mask(u_err_mask),
        .first_vec(u_first_vec), .first_valid(u_first_valid), .busy(u_busy), .pass(u_pass));

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: tracks how many consecutive cycles the sampled vector
    // has been unchanged; a vector is judged once, when that run reaches SETTLE.
    // Statistics are kept as plain integers; saturation is min() at check time.
    logic [2:0]       mq, mprev;
    int               sc, m_err, m_chk;
    logic [N_DUT-1:0] m_mask;
    logic [2:0]       m_first;
    logic             m_fv;

    function automatic logic golden_of(input logic [2:0] v);
        return ~((v[2] | v[1]) & v[0]);
    endfunction

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        mq = '0; mprev = '0; sc = 0;
        m_err = 0; m_chk = 0; m_mask = '0; m_first = '0; m_fv = 1'b0;
    endtask

    task automatic model_edge();
        logic [N_DUT-1:0] mis;
        if (clear) begin
            m_err = 0; m_chk = 0; m_mask = '0; m_first = '0; m_fv = 1'b0; sc = 0;
        end else if (mq != mprev) begin
            sc = 0;
        end else begin
            if (sc == SETTLE) begin
                for (int i = 0; i < N_DUT; i++) mis[i] = (dut_y[i] !== golden_of(mq));
                m_err += $countones(mis);
                m_chk++;
                m_mask |= mis;
                if (mis != '0 && !m_fv) begin m_first = mq; m_fv = 1'b1; end
            end
            if (sc <= SETTLE) sc++;
        end
        mprev = mq;
        mq = {a, b, c};
    endtask

    task automatic check_model();
        chk("model_main",
            {err_cnt, check_cnt, err_mask, first_vec, first_valid, pass},
            {8'(sat(m_err, CNT_W)), 8'(sat(m_chk, CNT_W)), m_mask, m_first, m_fv,
             1'((m_chk != 0) && !m_fv)});
        chk("model_sat",
            {s_err_cnt, s_check_cnt, s_err_mask, s_first_vec, s_first_valid, s_pass},
            {3'(sat(m_err, CNT_WS)), 3'(sat(m_chk, CNT_WS)), m_mask, m_first, m_fv,
             1'((m_chk != 0) && !m_fv)});
    endtask

    task automatic step(input bit do_chk);
        model_edge();
        @(posedge clk);
        #1;
        if (do_chk) check_model();
    endtask

    typedef struct {
        logic [2:0] abc;
        logic [2:0] y;
        int         err;
        int         chkn;
        logic [2:0] mask;
        logic [2:0] first;
        logic       fv;
    } vec_t;

    vec_t tbl[10];

    initial begin
        bit found;

        // golden by {a,b,c}: 1,1,1,0,1,0,1,0
        tbl[0] = '{3'b000, 3'b111, 0, 1, 3'b000, 3'b000, 1'b0};
        tbl[1] = '{3'b001, 3'b111, 0, 2, 3'b000, 3'b000, 1'b0};
        tbl[2] = '{3'b010, 3'b111, 0, 3, 3'b000, 3'b000, 1'b0};
        tbl[3] = '{3'b011, 3'b000, 0, 4, 3'b000, 3'b000, 1'b0};
        tbl[4] = '{3'b100, 3'b111, 0, 5, 3'b000, 3'b000, 1'b0};
        tbl[5] = '{3'b101, 3'b000, 0, 6, 3'b000, 3'b000, 1'b0};
        tbl[6] = '{3'b110, 3'b111, 0, 7, 3'b000, 3'b000, 1'b0};
        tbl[7] = '{3'b111, 3'b000, 0, 8, 3'b000, 3'b000, 1'b0};
        tbl[8] = '{3'b101, 3'b101, 2, 9, 3'b101, 3'b101, 1'b1};
        tbl[9] = '{3'b011, 3'b111, 5, 10, 3'b111, 3'b101, 1'b1};

        // ---- reset and first settle ----
        rst_n = 1'b0; {a, b, c} = 3'b000; dut_y = 3'b111; clear = 1'b0;
        #12;
        chk("reset_state", {err_cnt, check_cnt, err_mask, first_vec, first_valid, busy, pass},
            {8'd0, 8'd0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        chk("settle_busy0", busy, 1'b1);
        step(1);
        chk("s1_first_check_state", {u_busy, u_check_cnt}, {1'b0, 8'd0});
        chk("settle_busy1", {busy, check_cnt}, {1'b1, 8'd0});
        step(1);
        chk("s1_first_compare", u_check_cnt, 8'd1);
        chk("settle_busy2", {busy, check_cnt}, {1'b1, 8'd0});
        step(1);
        chk("settle_busy3", {busy, check_cnt}, {1'b1, 8'd0});
        step(1);
        chk("settle_check_state", {busy, check_cnt}, {1'b0, 8'd0});
        step(1);
        chk("first_compare", {check_cnt, err_cnt, pass}, {8'd1, 8'd0, 1'b1});

        // ---- table: all vectors, then injected mismatches ----
        clear = 1'b1; step(1); clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            {a, b, c} = tbl[i].abc;
            dut_y     = tbl[i].y;
            repeat (10) step(1);
            chk($sformatf("tbl%0d", i),
                {err_cnt, check_cnt, err_mask, first_vec, first_valid, pass},
                {8'(tbl[i].err), 8'(tbl[i].chkn), tbl[i].mask, tbl[i].first, tbl[i].fv,
                 1'(tbl[i].fv == 1'b0)});
        end
        chk("s1_table_count", u_check_cnt, 8'd10);

        // ---- toggling faster than SETTLE: no compares ----
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) c = ~c;
            step(1);
            if (k >= 1) chk($sformatf("toggle_busy%0d", k), busy, 1'b1);
        end
        chk("toggle_no_cmp", {check_cnt, u_check_cnt}, {8'd10, 8'd10});
        repeat (12) step(1);
        chk("toggle_one_cmp", {check_cnt, u_check_cnt}, {8'd11, 8'd11});

        // ---- clear on the CHECK cycle ----
        {a, b, c} = 3'b110; dut_y = 3'b111;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (k >= 1 && busy == 1'b0) found = 1'b1;
        end
        chk("reach_check", found, 1'b1);
        clear = 1'b1; step(1); clear = 1'b0;
        chk("clear_stats", {err_cnt, check_cnt, err_mask, first_vec, first_valid, busy, pass},
            {8'd0, 8'd0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0});
        repeat (4) step(1);
        chk("clear_no_early", check_cnt, 8'd0);
        step(1);
        chk("clear_recompare", check_cnt, 8'd1);

        // ---- async reset mid-SETTLE ----
        {a, b, c} = 3'b001; dut_y = 3'b000;
        repeat (3) step(1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {err_cnt, check_cnt, err_mask, first_valid, busy, pass},
            {8'd0, 8'd0, 3'b000, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;
        {a, b, c} = 3'b000;
        model_reset();
        rst_n = 1'b1;

        // ---- saturation: 8 vectors, every variant wrong ----
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            {a, b, c} = vv;
            dut_y = golden_of(vv) ? 3'b000 : 3'b111;
            repeat (10) step(1);
        end
        chk("sat_small", {s_err_cnt, s_check_cnt, s_err_mask}, {3'd7, 3'd7, 3'b111});
        chk("sat_main", {err_cnt, check_cnt, first_vec, first_valid}, {8'd24, 8'd8, 3'b000, 1'b1});

        // ---- X on variant 1 counts as a mismatch ----
        clear = 1'b1; step(1); clear = 1'b0;
        {a, b, c} = 3'b010; dut_y = 3'b1x1;
        repeat (10) step(1);
        chk("x_variant", {err_mask, err_cnt, first_vec, first_valid}, {3'b010, 8'd1, 3'b010, 1'b1});

        // ---- randomized run against the model ----
        clear = 1'b1; step(1); clear = 1'b0;
        begin
            int hold = 0;
            logic [2:0] v = 3'b000;
            for (int n = 0; n < 1500; n++) begin
                if (hold == 0) begin
                    v = 3'($urandom_range(0, 7));
                    hold = $urandom_range(1, 9);
                end
                hold--;
                {a, b, c} = v;
                dut_y = {N_DUT{golden_of(v)}};
                if ($urandom_range(0, 5) == 0) dut_y = dut_y ^ 3'($urandom_range(0, 7));
                clear = ($urandom_range(0, 299) == 0);
                step(1);
            end
            clear = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/oai_result_checker.md
Name: oai_result_checker

Overview:
- Downstream consumer of the OAI gate-level variants. Samples the shared stimulus (a, b, c) and each variant's output, and waits for a programmable settle window after every stimulus change. It then compares each output against the golden function y = ~((a | b) & c).
- Accumulates mismatch statistics and a sticky per-variant fail mask, so a bench or board can report pass/fail without waveform inspection.

Parameters:
- N_DUT, 3, number of OAI variant outputs compared in parallel.
- SETTLE, 4, clock cycles the sampled stimulus must stay stable before a compare (range 1..255).
- CNT_W, 8, width of the error and check counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  1  stimulus bit a, shared with the variants.
- b  input  1  stimulus bit b.
- c  input  1  stimulus bit c.
- dut_y  input  N_DUT  variant outputs; bit i is variant i.
- clear  input  1  synchronous statistics clear.
- err_cnt  output  CNT_W  number of (vector, variant) mismatches; saturating.
- check_cnt  output  CNT_W  number of settled vectors compared; saturating.
- err_mask  output  N_DUT  sticky; bit i set once variant i has mismatched.
- first_vec  output  3  {a,b,c} of the first mismatching vector.
- first_valid  output  1  first_vec holds a captured vector.
- busy  output  1  high in SETTLE state.
- pass  output  1  check_cnt != 0 and first_valid == 0.

Behaviour:
- Sampling
  - abc_q <= {a,b,c} every clock.
  - abc_prev <= abc_q.
  - change = (abc_q != abc_prev).
  - golden = ~((abc_q[2] | abc_q[1]) & abc_q[0]).
- Reset (rst_n low, asynchronous)
  - abc_q = 0, abc_prev = 0.
  - err_cnt = 0, check_cnt = 0, err_mask = 0, first_vec = 0, first_valid = 0.
  - Settle counter = SETTLE; state = SETTLE.
  - Hence busy = 1 and pass = 0.
- FSM states: SETTLE, CHECK, HOLD.
  - SETTLE: when change = 1, reload counter to SETTLE. Otherwise decrement. When the counter reaches 1 with change = 0, go to CHECK.
  - CHECK: lasts exactly one cycle and performs the compare (below). Then go to HOLD. If change = 1 in this cycle, skip the compare and go to SETTLE with counter reloaded.
  - HOLD: no compares. When change = 1, go to SETTLE with counter reloaded.
- Latency: a vector held stable on abc_q for SETTLE consecutive cycles is compared exactly once, in the following cycle. Each distinct settled vector counts once, including a return to a previous value.
- Compare (CHECK cycle, no clear)
  - mis[i] = (dut_y[i] !== golden); an X or Z output counts as a mismatch.
  - err_cnt += popcount(mis), saturating at 2^CNT_W - 1.
  - check_cnt += 1, saturating.
  - err_mask |= mis.
  - If mis != 0 and first_valid == 0: first_vec <= abc_q, first_valid <= 1.
- clear
  - Zeroes err_cnt, check_cnt, err_mask, first_vec and first_valid.
  - Forces SETTLE with counter reloaded.
  - Clear wins over a same-cycle compare; that compare is discarded.
  - abc_q and abc_prev are unaffected.
- Boundary cases
  - Stimulus toggling faster than SETTLE produces no compares and keeps busy high.
  - With SETTLE = 1, a vector stable for one cycle is compared in the next cycle.
  - Counters hold at all-ones; err_mask and first_vec stay sticky.
  - Reset asserted mid-SETTLE or mid-CHECK discards any pending compare immediately.

Test Plan:
- Reset, then hold a=b=c=0 with dut_y=3'b111 -> busy for 4 cycles, then one compare; check_cnt=1, err_cnt=0, pass=1.
- Step through all 8 vectors (changes 10 cycles apart) with correct outputs -> check_cnt=8, err_cnt=0, err_mask=0, pass=1.
- Vector {a,b,c}=3'b101 with dut_y=3'b101 (golden 0; variant 0 and variant 2 outputs wrong) -> err_cnt=2, err_mask=3'b101, first_vec=3'b101, first_valid=1, pass=0.
  - Then vector 3'b011 with all outputs wrong -> err_cnt=5, err_mask=3'b111, first_vec still 3'b101.
- Toggle c every 2 cycles for 20 cycles (SETTLE=4) -> check_cnt unchanged and busy stays 1; stop toggling -> exactly one compare after 4 stable cycles.
- Pulse clear on the CHECK cycle -> all statistics 0, no increment, next compare follows 4 settle cycles.
  - Assert rst_n low mid-SETTLE -> outputs go to reset values with no clock edge.
- CNT_W=3, 8 mismatching vectors on 3 variants -> err_cnt saturates at 7.
  - Variant 1 driven X -> err_mask[1]=1.
